// File: rtl/tx_signal_watchdog.sv
// tx_signal_watchdog
// ------------------
// Watches the baseband IQ stream leaving the OFDM transmitter and raises a
// registered abort when the stream looks wrong. Three detectors run while a
// packet is active:
//   - DC bias: running sum of per-sample signs over a sliding window of
//     2^LOG2_SUM_LEN samples, per channel; armed once the window has filled.
//   - zero run: consecutive all-zero samples (build option, see below).
//   - length: sample count versus the length latched at packet start
//     (overrun at any time, underrun when the packet ends).
//
// Build option:
//   OPENOFDM_TX_WATCHDOG_ZERO_RUN_EN  when defined, the zero-run detector is
//                                     built; otherwise abort_cause[1] is tied 0
//                                     and zero_run_th is ignored.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   enable              watchdog enable; low forces idle and suppresses aborts
//   tx_start, tx_end    single-cycle packet start / end pulses
//   i_data, q_data      signed samples, qualified by iq_valid
//   expected_len        packet length in samples, latched at tx_start
//   len_margin          length tolerance in samples
//   dc_running_sum_th   signed DC threshold on |sum_i| / |sum_q|
//   zero_run_th         zero-run threshold, 0 disables
//   tx_abort            abort request, high for ABORT_HOLD cycles per event
//   abort_cause         {length, zero run, DC}, latched until the next packet
//   abort_count         saturating count of abort events

module tx_signal_watchdog #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int LOG2_SUM_LEN  = 6,
  parameter int LEN_WIDTH     = 16,
  parameter int ABORT_HOLD    = 16
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            enable,
  input  logic                            tx_start,
  input  logic                            tx_end,
  input  logic signed [IQ_DATA_WIDTH-1:0] i_data,
  input  logic signed [IQ_DATA_WIDTH-1:0] q_data,
  input  logic                            iq_valid,
  input  logic        [LEN_WIDTH-1:0]     expected_len,
  input  logic        [7:0]               len_margin,
  input  logic signed [LOG2_SUM_LEN+1:0]  dc_running_sum_th,
  input  logic        [7:0]               zero_run_th,
  output logic                            tx_abort,
  output logic        [2:0]               abort_cause,
  output logic        [15:0]              abort_count
);

  localparam int unsigned WIN = 1 << LOG2_SUM_LEN;
  localparam int SW  = LOG2_SUM_LEN + 2;
  localparam int FW  = LOG2_SUM_LEN + 1;
  localparam int LW1 = LEN_WIDTH + 1;
  localparam int HW  = (ABORT_HOLD > 1) ? $clog2(ABORT_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_ABORT_HOLD
  } state_t;

  state_t state, state_nxt;

  logic [HW-1:0]        hold_cnt;
  logic                 clear_pkt;
  logic                 abort_evt;
  logic                 acc;
  logic                 end_q;
  logic                 fake_neg;

  logic [1:0]           sr_i [WIN];
  logic [1:0]           sr_q [WIN];
  logic signed [SW-1:0] sum_i, sum_q;
  logic signed [SW-1:0] abs_i, abs_q;
  logic [FW-1:0]        fill;
  logic [LEN_WIDTH-1:0] sample_cnt;
  logic [LEN_WIDTH-1:0] exp_q;

  logic [1:0]           sgn_i, sgn_q;
  logic [LW1-1:0]       len_hi;
  logic [LEN_WIDTH-1:0] len_lo;
  logic                 viol_dc, viol_zero, viol_len, viol_any;

  // 2-bit sign code: 2'b01 = +1, 2'b11 = -1. Zero uses the alternating fake
  // sign so a silent stream does not accumulate as DC.
  function automatic logic [1:0] sign_of(input logic signed [IQ_DATA_WIDTH-1:0] x,
                                         input logic fake);
    if (x == '0) return fake ? 2'b11 : 2'b01;
    else if (x[IQ_DATA_WIDTH-1]) return 2'b11;
    else return 2'b01;
  endfunction

  function automatic logic signed [SW-1:0] sext(input logic [1:0] s);
    return {{(SW-2){s[1]}}, s};
  endfunction

  assign sgn_i = sign_of(i_data, fake_neg);
  assign sgn_q = sign_of(q_data, fake_neg);

  // ---------------------------------------------------------------------------
  // Violation evaluation on registered packet state
  // ---------------------------------------------------------------------------
  assign abs_i   = sum_i[SW-1] ? -sum_i : sum_i;
  assign abs_q   = sum_q[SW-1] ? -sum_q : sum_q;
  assign viol_dc = (fill == FW'(WIN)) &&
                   ((abs_i >= dc_running_sum_th) || (abs_q >= dc_running_sum_th));

  // Upper bound is one bit wider so expected_len + margin cannot wrap.
  assign len_hi   = {1'b0, exp_q} + LW1'(len_margin);
  assign len_lo   = (exp_q > LEN_WIDTH'(len_margin)) ? exp_q - LEN_WIDTH'(len_margin) : '0;
  assign viol_len = ({1'b0, sample_cnt} > len_hi) || (end_q && (sample_cnt < len_lo));

`ifdef OPENOFDM_TX_WATCHDOG_ZERO_RUN_EN
  logic [7:0] zero_run;

  assign viol_zero = (zero_run_th != '0) && (zero_run >= zero_run_th);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero_run <= '0;
    end else if (clear_pkt) begin
      zero_run <= '0;
    end else if (acc) begin
      if ((i_data == '0) && (q_data == '0)) begin
        if (zero_run != '1) zero_run <= zero_run + 8'd1;
      end else begin
        zero_run <= '0;
      end
    end
  end
`else
  logic unused_zero_run_th;

  assign unused_zero_run_th = ^zero_run_th;
  assign viol_zero          = 1'b0;
`endif

  assign viol_any = viol_dc | viol_zero | viol_len;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    clear_pkt = 1'b0;
    abort_evt = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            state_nxt = S_ACTIVE;
            clear_pkt = 1'b1;
          end
        end
        S_ACTIVE: begin
          // A violation already present in the registered state is reported
          // before a restart can discard it; restart outranks a pending end.
          if (viol_any) begin
            state_nxt = S_ABORT_HOLD;
            abort_evt = 1'b1;
          end else if (tx_start) begin
            clear_pkt = 1'b1;
          end else if (end_q) begin
            state_nxt = S_IDLE;
          end
        end
        S_ABORT_HOLD: begin
          if (hold_cnt == '0) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Samples are accumulated only while the packet stays active this cycle.
  assign acc = iq_valid && (state == S_ACTIVE) && (state_nxt == S_ACTIVE) && !clear_pkt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      tx_abort    <= 1'b0;
      abort_cause <= '0;
      abort_count <= '0;
    end else begin
      state    <= state_nxt;
      tx_abort <= (state_nxt == S_ABORT_HOLD);
      if (abort_evt) begin
        hold_cnt <= HW'(ABORT_HOLD - 1);
      end else if ((state == S_ABORT_HOLD) && (hold_cnt != '0)) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      if (clear_pkt) begin
        abort_cause <= '0;
      end else if (abort_evt) begin
        abort_cause <= {viol_len, viol_zero, viol_dc};
        if (abort_count != '1) abort_count <= abort_count + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-packet datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fake_neg   <= 1'b0;
      end_q      <= 1'b0;
      sum_i      <= '0;
      sum_q      <= '0;
      fill       <= '0;
      sample_cnt <= '0;
      exp_q      <= '0;
      for (int unsigned n = 0; n < WIN; n++) begin
        sr_i[n] <= '0;
        sr_q[n] <= '0;
      end
    end else begin
      if (iq_valid) fake_neg <= ~fake_neg;

      // tx_end is registered so underrun is judged on the final count,
      // including a sample that arrives with the end pulse.
      end_q <= (state_nxt == S_ACTIVE) && !clear_pkt && (end_q || tx_end);

      if (clear_pkt) begin
        sum_i      <= '0;
        sum_q      <= '0;
        fill       <= '0;
        sample_cnt <= '0;
        exp_q      <= expected_len;
        for (int unsigned n = 0; n < WIN; n++) begin
          sr_i[n] <= '0;
          sr_q[n] <= '0;
        end
      end else if (acc) begin
        // Cleared window slots hold 0, so the sum stays exact during fill.
        sum_i <= sum_i + sext(sgn_i) - sext(sr_i[WIN-1]);
        sum_q <= sum_q + sext(sgn_q) - sext(sr_q[WIN-1]);
        sr_i[0] <= sgn_i;
        sr_q[0] <= sgn_q;
        for (int unsigned n = 1; n < WIN; n++) begin
          sr_i[n] <= sr_i[n-1];
          sr_q[n] <= sr_q[n-1];
        end
        if (fill != FW'(WIN)) fill <= fill + FW'(1);
        if (sample_cnt != '1) sample_cnt <= sample_cnt + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tx_signal_watchdog.sv
// Directed bench for tx_signal_watchdog. Stimulus pushes each expected abort
// event (cause, count, rise cycle) into a queue; a monitor pops on every
// tx_abort rise and checks the event, its hold width and cause stability.

module tb_tx_signal_watchdog;

  localparam int IQW = 16;
  localparam int L   = 6;
  localparam int LW  = 16;
  localparam int AH  = 16;

  logic                   clk;
  logic                   rstn;
  logic                   enable;
  logic                   tx_start;
  logic                   tx_end;
  logic signed [IQW-1:0]  i_data;
  logic signed [IQW-1:0]  q_data;
  logic                   iq_valid;
  logic [LW-1:0]          expected_len;
  logic [7:0]             len_margin;
  logic signed [L+1:0]    dc_running_sum_th;
  logic [7:0]             zero_run_th;
  logic                   tx_abort;
  logic [2:0]             abort_cause;
  logic [15:0]            abort_count;

  tx_signal_watchdog #(
    .IQ_DATA_WIDTH(IQW),
    .LOG2_SUM_LEN (L),
    .LEN_WIDTH    (LW),
    .ABORT_HOLD   (AH)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .enable           (enable),
    .tx_start         (tx_start),
    .tx_end           (tx_end),
    .i_data           (i_data),
    .q_data           (q_data),
    .iq_valid         (iq_valid),
    .expected_len     (expected_len),
    .len_margin       (len_margin),
    .dc_running_sum_th(dc_running_sum_th),
    .zero_run_th      (zero_run_th),
    .tx_abort         (tx_abort),
    .abort_cause      (abort_cause),
    .abort_count      (abort_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  cause;
    logic [15:0] count;
    int          rise_cyc;
    bit          chk_w;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;
  int   exp_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic drive(input logic v, input int i, input int q, input logic st, input logic en);
    iq_valid = v;
    i_data   = IQW'(i);
    q_data   = IQW'(q);
    tx_start = st;
    tx_end   = en;
    @(posedge clk);
    #1;
    iq_valid = 1'b0;
    tx_start = 1'b0;
    tx_end   = 1'b0;
    i_data   = '0;
    q_data   = '0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic start_pkt(input int len, input int margin);
    expected_len = LW'(len);
    len_margin   = 8'(margin);
    drive(1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  // Balanced QPSK: I alternates every sample, Q every two samples.
  task automatic qpsk(input int n, input bit end_last);
    for (int s = 0; s < n; s++)
      drive(1'b1, (s % 2 != 0) ? -1000 : 1000, ((s / 2) % 2 != 0) ? -1000 : 1000,
            1'b0, end_last && (s == n - 1));
  endtask

  task automatic zeros(input int n, input bit end_last);
    for (int s = 0; s < n; s++) drive(1'b1, 0, 0, 1'b0, end_last && (s == n - 1));
  endtask

  // Called right after the triggering edge k: abort must rise after edge k+1.
  task automatic expect_abort(input logic [2:0] cause, input bit chk_w);
    exp_t e;
    if (exp_count < 65535) exp_count++;
    e.cause    = cause;
    e.count    = 16'(exp_count);
    e.rise_cyc = cyc + 1;
    e.chk_w    = chk_w;
    sbq.push_back(e);
  endtask

  // Monitor
  initial begin
    exp_t cur;
    bit   prev;
    bit   have;
    int   width;
    prev  = 1'b0;
    have  = 1'b0;
    width = 0;
    forever begin
      @(negedge clk);
      if (tx_abort && !prev) begin
        width = 1;
        if (sbq.size() == 0) begin
          vecs++;
          errs++;
          have = 1'b0;
          $display("FAIL unexpected_abort: tx_abort rose at cycle %0d, expected none", cyc);
        end else begin
          cur  = sbq.pop_front();
          have = 1'b1;
          chk("abort_rise_cycle", cyc, cur.rise_cyc);
          chk("abort_cause", 32'(abort_cause), 32'(cur.cause));
          chk("abort_count", 32'(abort_count), 32'(cur.count));
        end
      end else if (tx_abort) begin
        width++;
      end else if (prev && have) begin
        if (cur.chk_w) begin
          chk("abort_hold_width", width, AH);
          chk("abort_cause_stable", 32'(abort_cause), 32'(cur.cause));
        end
        have = 1'b0;
      end
      prev = tx_abort;
    end
  end

  initial begin
    rstn              = 1'b0;
    enable            = 1'b0;
    tx_start          = 1'b0;
    tx_end            = 1'b0;
    iq_valid          = 1'b0;
    i_data            = '0;
    q_data            = '0;
    expected_len      = '0;
    len_margin        = '0;
    dc_running_sum_th = 8'sd40;
    zero_run_th       = 8'd10;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_abort", 32'(tx_abort), 0);
    chk("reset_cause", 32'(abort_cause), 0);
    chk("reset_count", 32'(abort_count), 0);
    rstn   = 1'b1;
    enable = 1'b1;
    idle(2);

    // Clean packet, tx_end with the last sample.
    start_pkt(160, 4);
    qpsk(160, 1'b1);
    idle(30);
    chk("clean_count", 32'(abort_count), 0);
    chk("clean_cause", 32'(abort_cause), 0);

    // DC: constant positive I, alternating Q; arms at sample 64.
    start_pkt(1000, 4);
    for (int s = 0; s < 64; s++) drive(1'b1, 500, (s % 2 != 0) ? -700 : 700, 1'b0, 1'b0);
    expect_abort(3'b001, 1'b1);
    idle(25);
    chk("dc_count_after_hold", 32'(abort_count), exp_count);
    chk("dc_cause_after_hold", 32'(abort_cause), 1);

    // Zero run after the DC window has filled: 9 zeros, data, 10 zeros.
    start_pkt(87, 4);
    qpsk(64, 1'b0);
    zeros(9, 1'b0);
    qpsk(4, 1'b0);
    zeros(10, 1'b1);
`ifdef OPENOFDM_TX_WATCHDOG_ZERO_RUN_EN
    expect_abort(3'b010, 1'b1);
    idle(25);
`else
    idle(25);
    chk("zero_disabled_cause", 32'(abort_cause), 0);
`endif
    chk("zero_count", 32'(abort_count), exp_count);

    // Overrun: 104 samples allowed, sample 105 violates.
    start_pkt(100, 4);
    qpsk(105, 1'b0);
    expect_abort(3'b100, 1'b1);
    idle(25);

    // Underrun at 95, none at 96.
    start_pkt(100, 4);
    qpsk(95, 1'b1);
    expect_abort(3'b100, 1'b1);
    idle(25);
    start_pkt(100, 4);
    qpsk(96, 1'b1);
    idle(10);
    chk("no_underrun_count", 32'(abort_count), exp_count);
    chk("no_underrun_cause", 32'(abort_cause), 0);

    // Reset five cycles into the hold.
    start_pkt(1000, 4);
    for (int s = 0; s < 64; s++) drive(1'b1, 500, (s % 2 != 0) ? -700 : 700, 1'b0, 1'b0);
    expect_abort(3'b001, 1'b0);
    for (int t = 0; t < 10 && !tx_abort; t++) @(negedge clk);
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midhold_reset_tx_abort", 32'(tx_abort), 0);
    chk("midhold_reset_cause", 32'(abort_cause), 0);
    chk("midhold_reset_count", 32'(abort_count), 0);
    exp_count = 0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);

    // Packet after reset is accepted normally.
    start_pkt(100, 4);
    qpsk(105, 1'b0);
    expect_abort(3'b100, 1'b1);
    idle(25);

    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/tx_signal_watchdog.md
# tx_signal_watchdog

Transmit-side counterpart of the receiver signal watchdog: it monitors the baseband IQ stream that openofdm_tx hands to the DAC path and raises a registered abort when the stream is abnormal. Abnormal means DC-biased (sign running sum over a sliding window), stuck at zero, or of the wrong length versus the length announced at packet start. It sits between the openofdm_tx sample output and the tx interface/IQ FIFO. The xpu/tx_intf consumes `tx_abort` to flush the packet and count the failure.

## Interface
Parameters:
- IQ_DATA_WIDTH, 16, width of each of I and Q (signed)
- LOG2_SUM_LEN, 6, log2 of DC window length (window = 2^LOG2_SUM_LEN samples)
- LEN_WIDTH, 16, width of sample-length fields
- ABORT_HOLD, 16, cycles `tx_abort` stays high per event (≥1)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- enable  in  1  watchdog enable; low forces IDLE, no aborts
- tx_start  in  1  one-cycle pulse at packet start
- tx_end  in  1  one-cycle pulse coincident with, or after, the last sample
- i_data, q_data  in  IQ_DATA_WIDTH each  signed samples
- iq_valid  in  1  sample qualifier
- expected_len  in  LEN_WIDTH  packet length in samples; latched at tx_start
- len_margin  in  8  tolerance on length, samples
- dc_running_sum_th  in  LOG2_SUM_LEN+2  signed; DC abort when |sum_i| or |sum_q| ≥ th
- zero_run_th  in  8  consecutive all-zero samples that trigger abort; 0 disables
- tx_abort  out  1  abort request, registered
- abort_cause  out  3  bit0 DC, bit1 zero run, bit2 length; latched
- abort_count  out  16  saturating count of abort events

## Operation
- FSM states: IDLE, ACTIVE, ABORT_HOLD.
  - IDLE→ACTIVE on tx_start with enable=1.
  - ACTIVE→IDLE on tx_end with no violation.
  - ACTIVE→ABORT_HOLD on any violation.
  - ABORT_HOLD→IDLE after ABORT_HOLD cycles.
  - enable=0 in any state → IDLE next edge, tx_abort=0.
- On entry to ACTIVE, clear all per-packet state: sign window, both sums, fill counter, sample counter, zero-run counter, abort_cause. Latch expected_len.
- Sign mapping per sample: −1 if MSB set, +1 if positive. A zero component uses an alternating fake sign that toggles on every iq_valid (reset value +1), so silence is not counted as DC.
- DC window:
  - 2-bit signs go into a 2^LOG2_SUM_LEN-deep shift register per channel.
  - sum ← sum + new − oldest, signed width LOG2_SUM_LEN+2, no overflow possible.
  - DC check is armed only once the fill counter reaches 2^LOG2_SUM_LEN samples within the packet.
- Zero run: counter increments on a valid sample with i==0 and q==0, resets on any non-zero valid sample, and saturates at 255. Violation when zero_run_th≠0 and counter ≥ zero_run_th.
- Length:
  - The sample counter counts valid samples in ACTIVE and saturates.
  - Overrun violation when count > expected_len + len_margin.
  - At tx_end, underrun violation when count < expected_len − len_margin; the subtraction saturates at 0.
- Simultaneous violations: all applicable cause bits are set in the same event. abort_count increments once per event and saturates at 0xFFFF.
- tx_start while ACTIVE restarts the packet. tx_start during ABORT_HOLD is ignored. tx_end in IDLE is ignored. tx_start and tx_end together in ACTIVE: restart wins.

## Timing
- Reset values: tx_abort=0, abort_cause=0, abort_count=0, state IDLE, fake sign +1.
- Sample presented with iq_valid at edge k updates the sums and counters at edge k. Violation is evaluated on the registered state, and tx_abort rises after edge k+1: latency 2 cycles from sample to abort.
- tx_end sampled at edge k: underrun abort after edge k+1.
- tx_abort high for exactly ABORT_HOLD cycles. abort_cause is stable from the tx_abort rise until the next accepted tx_start.
- Asynchronous rstn assertion mid-operation: all outputs go to reset values immediately, with no glitch completion of ABORT_HOLD.

## Configuration
- Macro `OPENOFDM_TX_WATCHDOG_ZERO_RUN_EN`.
- Defined: the zero-run detector is compiled in as described.
- Undefined: the zero-run counter is removed, abort_cause[1] is tied 0, and zero_run_th is ignored. All other behaviour is unchanged.

## Test plan
- Clean packet: expected_len=160, margin=4, 160 random-sign QPSK samples (±1000), tx_end with the last sample → tx_abort never high, abort_count=0.
- DC with arming: LOG2_SUM_LEN=6, th=40, i=+500 constant, q random sign → no abort before sample 64. tx_abort rises 2 cycles after sample 64, cause=3'b001, held 16 cycles, abort_count=1.
- Zero run (macro defined): th=10, 9 zero samples mid-packet → no abort; 10 zero samples → abort, cause=3'b010. No DC abort during the zeros.
- Length: expected_len=100, margin=4. Sample 105 → overrun abort, cause=3'b100. Separate packet with tx_end after 95 samples → underrun abort; after 96 samples → none.
- Reset mid-hold: rstn low 5 cycles into ABORT_HOLD → tx_abort, abort_cause and abort_count become 0 immediately. Next tx_start is accepted normally.
- Macro undefined: repeat the zero-run test with 20 zeros → no abort, cause[1]=0.
